siso_shift_reg: RTL and testbench

// - Serial-in serial-out shift register: delays a 1-bit serial stream by DEPTH clock cycles.
// - Generic delay-line / serializer stage; sits between serial producer and consumer in one clock domain.
// - No enable or handshake; shifts on every rising clock edge when not in reset.
//

---
 rtl/siso_shift_reg.sv | 32 +++
 tb/tb_siso_shift_reg.sv | 118 +++++++++++
 2 files changed

// File: rtl/siso_shift_reg.sv
// Serial-in serial-out shift register: delays a 1-bit stream by DEPTH clock cycles.
// The output comes straight from the last stage, so there is no combinational path from in to out.
module siso_shift_reg #(
  parameter int               DEPTH       = 4,
  parameter logic [DEPTH-1:0] RESET_VALUE = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  logic [DEPTH-1:0] sr;

  // A single stage has no predecessor to shift from, so the slice
  // sr[DEPTH-2:0] must never be elaborated in that build.
  if (DEPTH == 1) begin : g_single
    // NOTE: non-blocking assignment keeps every stage sampling the pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sr <= RESET_VALUE;
      else     sr <= in;
    end
  end else begin : g_chain
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sr <= RESET_VALUE;
      else     sr <= {sr[DEPTH-2:0], in};
    end
  end

  assign out = sr[DEPTH-1];

endmodule

// File: tb/tb_siso_shift_reg.sv
// Directed bench for siso_shift_reg: a DEPTH=4 instance and a DEPTH=1 instance
// driven with hand-computed stimulus/response vectors.
module tb_siso_shift_reg;

  logic clk;
  logic rst, in, out;
  logic rst1, in1, out1;

  int n_checks = 0;
  int n_fail   = 0;

  siso_shift_reg #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (out)
  );

  siso_shift_reg #(.DEPTH(1)) dut1 (
    .clk (clk),
    .rst (rst1),
    .in  (in1),
    .out (out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bit i of ins is driven for edge i+1; bit i of exps is out just after that edge.
  task automatic run4(input string tag, input logic [31:0] ins, input logic [31:0] exps, input int n);
    for (int i = 0; i < n; i++) begin
      in = ins[i];
      step();
      check($sformatf("%s[%0d]", tag, i), {31'd0, out}, {31'd0, exps[i]});
    end
  endtask

  task automatic run1(input string tag, input logic [31:0] ins, input logic [31:0] exps, input int n);
    for (int i = 0; i < n; i++) begin
      in1 = ins[i];
      step();
      check($sformatf("%s[%0d]", tag, i), {31'd0, out1}, {31'd0, exps[i]});
    end
  endtask

  initial begin
    rst  = 1'b1;
    in   = 1'b1;
    rst1 = 1'b1;
    in1  = 1'b0;
    #1;
    check("reset_before_clk", {31'd0, out}, 32'd0);
    check("reset_before_clk_d1", {31'd0, out1}, 32'd0);

    // Reset held across two edges with in=1: nothing shifts in.
    for (int i = 0; i < 2; i++) begin
      step();
      check("reset_held_out", {31'd0, out}, 32'd0);
      check("reset_held_sr", {28'd0, dut.sr}, 32'd0);
    end

    // Release between edges; single 1 appears after the 4th edge for one cycle.
    rst = 1'b0;
    run4("latency", 32'b000001, 32'b001000, 6);

    // Alternating pattern 1,0,1,0 then zeros.
    run4("pattern", 32'b00000101, 32'b00101000, 8);

    // Fill with ones, then assert reset mid-cycle.
    run4("fill", 32'b1111, 32'b1000, 4);
    check("fill_sr", {28'd0, dut.sr}, 32'hF);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_out", {31'd0, out}, 32'd0);
    check("async_reset_sr", {28'd0, dut.sr}, 32'd0);
    in = 1'b1;
    step();
    check("reset_ignores_clk", {31'd0, out}, 32'd0);

    // After release, in=1: zeros for 3 edges, then 1.
    rst = 1'b0;
    run4("post_reset", 32'b11111, 32'b11000, 5);

    // Flush with zeros: out falls exactly 4 edges after in drops.
    run4("flush", 32'b0000, 32'b0111, 4);

    // Constant 1 for 8 edges, then 0 for 6.
    run4("const", 32'h00FF, 32'h07F8, 14);

    // DEPTH=1 build: out follows in one edge later.
    check("d1_reset_held", {31'd0, out1}, 32'd0);
    rst1 = 1'b0;
    run1("d1_toggle", 32'b101101, 32'b101101, 6);
    #3;
    rst1 = 1'b1;
    #1;
    check("d1_async_reset", {31'd0, out1}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
